// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: command-driven master that reads, writes, clears and dumps a register file over valid/ready ports
//   cmd_*  : command port (READ/WRITE/CLEAR/DUMP), accepted on cmd_valid & cmd_ready
//   rsp_*  : response port (read data, index, last flag), held until rsp_ready
//   busy   : high whenever a multi-cycle operation is in progress
//   rf_*   : registered write and read-select pins toward the register file, plus its read data
`timescale 1ns/1ps
module regfile_access_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_REGS = 32,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rs1,
  input  logic [ADDR_W-1:0] cmd_rs2,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data_a,
  output logic [DATA_W-1:0] rsp_data_b,
  output logic [ADDR_W-1:0] rsp_index,
  output logic              rsp_last,
  output logic              busy,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [ADDR_W-1:0] rf_rs1,
  output logic [ADDR_W-1:0] rf_rs2,
  input  logic [DATA_W-1:0] rf_da,
  input  logic [DATA_W-1:0] rf_db
);
  typedef enum logic [2:0] {IDLE, RD_CAP, RSP_WAIT, CLEAR, DUMP_CAP, DUMP_WAIT} state_t;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] LAST_PAIR = ADDR_W'(NUM_REGS - 2);
  state_t state;
  logic accept;
  assign cmd_ready = (state == IDLE) & ~rsp_valid;
  assign busy = state != IDLE;
  assign accept = cmd_valid & cmd_ready;
  // READ and DUMP share the capture and wait states; a READ response always has
  // rsp_last set, so the wait state's "last" test returns it straight to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rf_we <= 1'b0;
      rf_rd <= '0;
      rf_wdata <= '0;
      rf_rs1 <= '0;
      rf_rs2 <= '0;
      rsp_valid <= 1'b0;
      rsp_data_a <= '0;
      rsp_data_b <= '0;
      rsp_index <= '0;
      rsp_last <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          case (cmd_op)
            2'b00: begin
              rf_rs1 <= cmd_rs1;
              rf_rs2 <= cmd_rs2;
              state <= RD_CAP;
            end
            2'b01: begin
              rf_we <= 1'b1;
              rf_rd <= cmd_rd;
              rf_wdata <= cmd_wdata;
            end
            2'b10: begin
              rf_we <= 1'b1;
              rf_rd <= '0;
              rf_wdata <= CLEAR_VALUE;
              state <= CLEAR;
            end
            default: begin
              rf_rs1 <= '0;
              rf_rs2 <= ADDR_W'(1);
              state <= DUMP_CAP;
            end
          endcase
        end
        RD_CAP, DUMP_CAP: begin
          rsp_valid <= 1'b1;
          rsp_data_a <= rf_da;
          rsp_data_b <= rf_db;
          rsp_index <= rf_rs1;
          rsp_last <= (state == RD_CAP) || (rf_rs1 == LAST_PAIR);
          state <= state == RD_CAP ? RSP_WAIT : DUMP_WAIT;
        end
        RSP_WAIT, DUMP_WAIT: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state <= rsp_last ? IDLE : DUMP_CAP;
          if (!rsp_last) begin
            rf_rs1 <= rf_rs1 + ADDR_W'(2);
            rf_rs2 <= rf_rs2 + ADDR_W'(2);
          end
        end
        CLEAR: begin
          if (rf_rd == LAST_IDX) begin
            state <= IDLE;
          end else begin
            rf_we <= 1'b1;
            rf_rd <= rf_rd + ADDR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb_regfile_access_ctrl: directed self-checking bench for regfile_access_ctrl driving a behavioural 32x32 register file
`timescale 1ns/1ps
module tb_regfile_access_ctrl;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_last, busy, rf_we, rf_clr;
  logic [1:0] cmd_op;
  logic [AW-1:0] cmd_rs1, cmd_rs2, cmd_rd, rsp_index, rf_rd, rf_rs1, rf_rs2;
  logic [DW-1:0] cmd_wdata, rsp_data_a, rsp_data_b, rf_wdata, rf_da, rf_db;
  logic [DW-1:0] rf [NR];
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < NR; i++) rf[i] <= '0;
    end else if (rf_we) begin
      rf[rf_rd] <= rf_wdata;
    end
  end
  assign rf_da = rf[rf_rs1];
  assign rf_db = rf[rf_rs2];
  regfile_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .CLEAR_VALUE('0)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b),
    .rsp_index(rsp_index), .rsp_last(rsp_last), .busy(busy), .rf_we(rf_we), .rf_rd(rf_rd),
    .rf_wdata(rf_wdata), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_da(rf_da), .rf_db(rf_db)
  );
  task automatic do_write(input logic [AW-1:0] rd, input logic [DW-1:0] d);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_rd = rd; cmd_wdata = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask
  task automatic do_read(input logic [AW-1:0] a1, input logic [AW-1:0] a2, output logic [DW-1:0] da, output logic [DW-1:0] db);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_rs1 = a1; cmd_rs2 = a2;
    @(negedge clk);
    cmd_valid = 1'b0;
    da = 'x; db = 'x;
    for (int i = 0; i < 10 && !rsp_valid; i++) @(negedge clk);
    if (rsp_valid) begin
      da = rsp_data_a; db = rsp_data_b;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask
  task automatic fill();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01;
    for (int i = 0; i < NR; i++) begin
      cmd_rd = AW'(i); cmd_wdata = 32'hA5A5_0000 + DW'(i);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b1; rf_clr = 1'b1;
    repeat (3) @(negedge clk);
    total++; if ({cmd_ready, busy, rf_we, rsp_valid, rsp_last} !== 5'b10000) begin bad++; $display("FAIL reset_ctl: got %b want 10000", {cmd_ready, busy, rf_we, rsp_valid, rsp_last}); end
    total++; if ({rf_rd, rf_rs1, rf_rs2, rsp_index} !== '0) begin bad++; $display("FAIL reset_idx: got %h want 0", {rf_rd, rf_rs1, rf_rs2, rsp_index}); end
    total++; if ({rf_wdata, rsp_data_a, rsp_data_b} !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", {rf_wdata, rsp_data_a, rsp_data_b}); end
    reset = 1'b0; rf_clr = 1'b0;
  endtask
  task automatic test_write_read();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_rd = 5; cmd_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    total++; if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin bad++; $display("FAIL wr_pins: got %h want %h", {rf_we, rf_rd, rf_wdata}, {1'b1, 5'd5, 32'hDEAD_BEEF}); end
    cmd_op = 2'b00; cmd_rs1 = 5; cmd_rs2 = 0;
    @(negedge clk);
    cmd_valid = 1'b0;
    total++; if ({rf_we, busy, cmd_ready, rsp_valid, rf_rs1, rf_rs2} !== {4'b0100, 5'd5, 5'd0}) begin bad++; $display("FAIL rd_cap: got %h want %h", {rf_we, busy, cmd_ready, rsp_valid, rf_rs1, rf_rs2}, {4'b0100, 5'd5, 5'd0}); end
    @(negedge clk);
    total++; if ({rsp_valid, rsp_data_a, rsp_data_b, rsp_index, rsp_last} !== {1'b1, 32'hDEAD_BEEF, 32'h0, 5'd5, 1'b1}) begin bad++; $display("FAIL rd_rsp: got %h want %h", {rsp_valid, rsp_data_a, rsp_data_b, rsp_index, rsp_last}, {1'b1, 32'hDEAD_BEEF, 32'h0, 5'd5, 1'b1}); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    total++; if ({rsp_valid, busy, cmd_ready} !== 3'b001) begin bad++; $display("FAIL rd_done: got %b want 001", {rsp_valid, busy, cmd_ready}); end
  endtask
  task automatic test_back_to_back();
    logic [DW-1:0] a, b;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_rd = 7; cmd_wdata = 32'h12;
    @(negedge clk);
    cmd_op = 2'b00; cmd_rs1 = 7; cmd_rs2 = 7;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    total++; if ({rsp_valid, rsp_data_a, rsp_data_b} !== {1'b1, 32'h12, 32'h12}) begin bad++; $display("FAIL raw_read: got %h want %h", {rsp_valid, rsp_data_a, rsp_data_b}, {1'b1, 32'h12, 32'h12}); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'b01;
    for (int i = 1; i <= 4; i++) begin
      cmd_rd = AW'(i); cmd_wdata = 32'h100 * DW'(i);
      @(negedge clk);
      total++; if ({rf_we, rf_rd, rf_wdata, cmd_ready} !== {1'b1, AW'(i), 32'h100 * DW'(i), 1'b1}) begin bad++; $display("FAIL b2b_wr%0d: got %h want %h", i, {rf_we, rf_rd, rf_wdata, cmd_ready}, {1'b1, AW'(i), 32'h100 * DW'(i), 1'b1}); end
    end
    cmd_valid = 1'b0;
    do_read(1, 2, a, b);
    total++; if ({a, b} !== {32'h100, 32'h200}) begin bad++; $display("FAIL b2b_rd12: got %h want %h", {a, b}, {32'h100, 32'h200}); end
    do_read(3, 4, a, b);
    total++; if ({a, b} !== {32'h300, 32'h400}) begin bad++; $display("FAIL b2b_rd34: got %h want %h", {a, b}, {32'h300, 32'h400}); end
  endtask
  task automatic test_rsp_hold();
    logic [DW-1:0] a, b;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_rs1 = 7; cmd_rs2 = 1;
    @(negedge clk);
    cmd_op = 2'b01; cmd_rd = 9; cmd_wdata = 32'hBAD;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      total++; if ({rsp_valid, rsp_data_a, rsp_data_b, rsp_index, cmd_ready, rf_we} !== {1'b1, 32'h12, 32'h100, 5'd7, 2'b00}) begin bad++; $display("FAIL hold%0d: got %h want %h", i, {rsp_valid, rsp_data_a, rsp_data_b, rsp_index, cmd_ready, rf_we}, {1'b1, 32'h12, 32'h100, 5'd7, 2'b00}); end
      if (i < 5) @(negedge clk);
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    total++; if ({rsp_valid, cmd_ready, rf_we} !== 3'b010) begin bad++; $display("FAIL hold_release: got %b want 010", {rsp_valid, cmd_ready, rf_we}); end
    do_read(9, 9, a, b);
    total++; if ({a, b} !== 64'h0) begin bad++; $display("FAIL ignored_cmd: got %h want 0", {a, b}); end
  endtask
  task automatic test_clear();
    logic [DW-1:0] a, b;
    int busy_n, we_n, idx_bad;
    fill();
    do_read(31, 6, a, b);
    total++; if ({a, b} !== {32'hA5A5_001F, 32'hA5A5_0006}) begin bad++; $display("FAIL fill: got %h want %h", {a, b}, {32'hA5A5_001F, 32'hA5A5_0006}); end
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b10;
    @(negedge clk);
    cmd_valid = 1'b0;
    busy_n = 0; we_n = 0; idx_bad = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      busy_n++;
      if (rf_we) begin
        if (rf_rd !== AW'(we_n) || rf_wdata !== '0) idx_bad++;
        we_n++;
      end
      @(negedge clk);
    end
    total++; if (busy_n !== 32) begin bad++; $display("FAIL clr_busy: got %0d want 32", busy_n); end
    total++; if (we_n !== 32) begin bad++; $display("FAIL clr_we: got %0d want 32", we_n); end
    total++; if (idx_bad !== 0) begin bad++; $display("FAIL clr_seq: got %0d bad beats want 0", idx_bad); end
    total++; if ({cmd_ready, rf_we, rsp_valid} !== 3'b100) begin bad++; $display("FAIL clr_end: got %b want 100", {cmd_ready, rf_we, rsp_valid}); end
    do_read(31, 0, a, b);
    total++; if ({a, b} !== 64'h0) begin bad++; $display("FAIL clr_rd: got %h want 0", {a, b}); end
  endtask
  task automatic test_dump();
    int k;
    logic [AW-1:0] ei;
    logic [DW-1:0] ea, eb;
    fill();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b11;
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 0;
    for (int i = 0; i < 400 && k < 16; i++) begin
      if (rsp_valid) begin
        ei = AW'(2 * k); ea = 32'hA5A5_0000 + DW'(2 * k); eb = ea + 32'h1;
        total++; if ({rsp_index, rsp_data_a, rsp_data_b, rsp_last, cmd_ready} !== {ei, ea, eb, k == 15, 1'b0}) begin bad++; $display("FAIL dump_beat%0d: got %h want %h", k, {rsp_index, rsp_data_a, rsp_data_b, rsp_last, cmd_ready}, {ei, ea, eb, k == 15, 1'b0}); end
      end
      rsp_ready = 1'($urandom_range(0, 1));
      if (rsp_valid && rsp_ready) k++;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    total++; if (k !== 16) begin bad++; $display("FAIL dump_beats: got %0d want 16", k); end
    total++; if ({rsp_valid, busy, cmd_ready} !== 3'b001) begin bad++; $display("FAIL dump_end: got %b want 001", {rsp_valid, busy, cmd_ready}); end
  endtask
  task automatic test_reset_mid();
    logic [DW-1:0] a, b;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b11;
    @(negedge clk);
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 40 && !(rsp_valid && rsp_index == 6); i++) @(negedge clk);
    total++; if ({rsp_valid, rsp_index} !== {1'b1, 5'd6}) begin bad++; $display("FAIL dump_beat4_seen: got %h want %h", {rsp_valid, rsp_index}, {1'b1, 5'd6}); end
    reset = 1'b1; rsp_ready = 1'b0;
    @(negedge clk);
    total++; if ({rsp_valid, busy, rf_we, rsp_last, rsp_index, rf_rs1, rf_rs2, rsp_data_a, rsp_data_b} !== '0) begin bad++; $display("FAIL rst_dump: got %h want 0", {rsp_valid, busy, rf_we, rsp_last, rsp_index, rf_rs1, rf_rs2, rsp_data_a, rsp_data_b}); end
    reset = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b10;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 40 && !(rf_we && rf_rd == 10); i++) @(negedge clk);
    total++; if ({rf_we, rf_rd} !== {1'b1, 5'd10}) begin bad++; $display("FAIL clr_idx10_seen: got %h want %h", {rf_we, rf_rd}, {1'b1, 5'd10}); end
    reset = 1'b1;
    @(negedge clk);
    total++; if ({rf_we, busy, rsp_valid, rf_rd, rf_wdata} !== '0) begin bad++; $display("FAIL rst_clr: got %h want 0", {rf_we, busy, rsp_valid, rf_rd, rf_wdata}); end
    reset = 1'b0;
    do_read(11, 31, a, b);
    total++; if ({a, b} !== {32'hA5A5_000B, 32'hA5A5_001F}) begin bad++; $display("FAIL rst_keep: got %h want %h", {a, b}, {32'hA5A5_000B, 32'hA5A5_001F}); end
    do_read(10, 9, a, b);
    total++; if ({a, b} !== 64'h0) begin bad++; $display("FAIL rst_cleared: got %h want 0", {a, b}); end
  endtask
  initial begin
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_rs1 = '0; cmd_rs2 = '0; cmd_rd = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; rf_clr = 1'b1;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_rsp_hold();
    test_clear();
    test_dump();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
